// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for handshake pipeline stage buffers.
//   pipe_state_t : occupancy of a stage (empty, one entry, two entries)
//   RV_NOP       : RISC-V canonical NOP (addi x0,x0,0), used as bubble word
// -----------------------------------------------------------------------------
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } pipe_state_t;

   localparam logic [31:0] RV_NOP = 32'h0000_0013;

endpackage : pipe_pkg

// File: rtl/pipe_slot.sv
// -----------------------------------------------------------------------------
// pipe_slot
// One {pc, inst} storage entry, loaded when 'load' is high, cleared
// asynchronously by 'clear'.
//   clk      : clock, rising edge
//   clear    : asynchronous active-high clear, zeroes the entry
//   load     : capture pc_in/inst_in at the next edge
//   pc_in    : address to store
//   inst_in  : word to store
//   pc_out   : stored address
//   inst_out : stored word
// -----------------------------------------------------------------------------
module pipe_slot
   import pipe_pkg::*;
#(
   parameter int ADDR_SIZE = 10,
   parameter int DATA_SIZE = 32
) (
   input  logic                 clk,
   input  logic                 clear,
   input  logic                 load,
   input  logic [ADDR_SIZE-1:0] pc_in,
   input  logic [DATA_SIZE-1:0] inst_in,
   output logic [ADDR_SIZE-1:0] pc_out,
   output logic [DATA_SIZE-1:0] inst_out
);

   logic [ADDR_SIZE-1:0] pc_d, pc_q;
   logic [DATA_SIZE-1:0] inst_d, inst_q;

   // Load-or-hold selection for the stored entry
   always_comb begin
      pc_d   = pc_q;
      inst_d = inst_q;
      if (load) begin
         pc_d   = pc_in;
         inst_d = inst_in;
      end else begin
         pc_d   = pc_q;
         inst_d = inst_q;
      end
   end

   // Entry storage with asynchronous clear
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         pc_q   <= {ADDR_SIZE{1'b0}};
         inst_q <= {DATA_SIZE{1'b0}};
      end else begin
         pc_q   <= pc_d;
         inst_q <= inst_d;
      end
   end

   assign pc_out   = pc_q;
   assign inst_out = inst_q;

endmodule : pipe_slot

// File: rtl/if_id_stage_buf.sv
// -----------------------------------------------------------------------------
// if_id_stage_buf
// IF/ID pipeline stage with valid/ready handshake on both sides, optional
// skid entry (SKID_EN=1) that makes ready_if depend on registered state only,
// and a synchronous flush that empties the stage and drops the incoming word.
//   clk       : clock, rising edge
//   clear     : asynchronous active-high reset
//   valid_if  : fetch presents a word
//   pc_if     : fetch PC
//   inst_if   : fetch word
//   ready_if  : stage can accept this cycle
//   flush     : kill held and incoming entries at the next edge
//   valid_id  : decode output valid
//   pc_id     : main-slot PC (not masked when invalid)
//   inst_id   : main-slot word, or BUBBLE_INST when invalid
//   ready_id  : decode accepts (low = stall)
// -----------------------------------------------------------------------------
module if_id_stage_buf
   import pipe_pkg::*;
#(
   parameter int                   DATA_SIZE   = 32,
   parameter int                   ADDR_SIZE   = 10,
   parameter int                   SKID_EN     = 1,
   parameter logic [DATA_SIZE-1:0] BUBBLE_INST = DATA_SIZE'(RV_NOP)
) (
   input  logic                 clk,
   input  logic                 clear,
   input  logic                 valid_if,
   input  logic [ADDR_SIZE-1:0] pc_if,
   input  logic [DATA_SIZE-1:0] inst_if,
   output logic                 ready_if,
   input  logic                 flush,
   output logic                 valid_id,
   output logic [ADDR_SIZE-1:0] pc_id,
   output logic [DATA_SIZE-1:0] inst_id,
   input  logic                 ready_id
);

   localparam bit HAS_SKID = (SKID_EN != 32'sd0);

   pipe_state_t          state_d, state_q;
   logic                 accept_s, retire_s, valid_s;
   logic                 m_load_s, s_load_s;
   logic [ADDR_SIZE-1:0] m_pc_in_s, m_pc_q, s_pc_q;
   logic [DATA_SIZE-1:0] m_inst_in_s, m_inst_q, s_inst_q;

   // Handshake and output decode from registered state
   always_comb begin
      valid_s = (state_q != ST_EMPTY);
      if (HAS_SKID) begin
         // Registered-only: breaks the ready_id -> ready_if path
         ready_if = (state_q != ST_SKID);
      end else begin
         ready_if = ready_id | ~valid_s;
      end
      valid_id = valid_s;
      pc_id    = m_pc_q;
      if (valid_s) begin
         inst_id = m_inst_q;
      end else begin
         inst_id = BUBBLE_INST;
      end
      accept_s = valid_if & ready_if;
      retire_s = valid_s & ready_id;
   end

   // Next-state and slot load control; flush overrides everything
   always_comb begin
      state_d     = state_q;
      m_load_s    = 1'b0;
      s_load_s    = 1'b0;
      m_pc_in_s   = pc_if;
      m_inst_in_s = inst_if;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept_s) begin
                  m_load_s = 1'b1;
                  state_d  = ST_FULL;
               end else begin
                  state_d  = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (retire_s && accept_s) begin
                  m_load_s = 1'b1;
                  state_d  = ST_FULL;
               end else if (retire_s) begin
                  state_d  = ST_EMPTY;
               end else if (accept_s && HAS_SKID) begin
                  // Output stalled while a word arrives: park it in S
                  s_load_s = 1'b1;
                  state_d  = ST_SKID;
               end else begin
                  state_d  = ST_FULL;
               end
            end
            ST_SKID: begin
               if (retire_s) begin
                  m_load_s    = 1'b1;
                  m_pc_in_s   = s_pc_q;
                  m_inst_in_s = s_inst_q;
                  state_d     = ST_FULL;
               end else begin
                  state_d     = ST_SKID;
               end
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
   end

   // Occupancy state register
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   pipe_slot #(
      .ADDR_SIZE (ADDR_SIZE),
      .DATA_SIZE (DATA_SIZE)
   ) u_main (
      .clk      (clk),
      .clear    (clear),
      .load     (m_load_s),
      .pc_in    (m_pc_in_s),
      .inst_in  (m_inst_in_s),
      .pc_out   (m_pc_q),
      .inst_out (m_inst_q)
   );

   if (HAS_SKID) begin : g_skid
      pipe_slot #(
         .ADDR_SIZE (ADDR_SIZE),
         .DATA_SIZE (DATA_SIZE)
      ) u_skid (
         .clk      (clk),
         .clear    (clear),
         .load     (s_load_s),
         .pc_in    (pc_if),
         .inst_in  (inst_if),
         .pc_out   (s_pc_q),
         .inst_out (s_inst_q)
      );
   end else begin : g_no_skid
      assign s_pc_q   = {ADDR_SIZE{1'b0}};
      assign s_inst_q = {DATA_SIZE{1'b0}};
   end

endmodule : if_id_stage_buf

// File: tb/tb_if_id_stage_buf.sv
// -----------------------------------------------------------------------------
// tb_if_id_stage_buf
// Drives a SKID_EN=1 instance (suffix 1) and a SKID_EN=0 instance (suffix 0)
// with shared clock/clear/flush/ready_id and separate fetch sides. A negedge
// monitor keeps a FIFO model per instance; directed sequences add
// hand-computed checks on top.
// -----------------------------------------------------------------------------
module tb_if_id_stage_buf;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct {
      logic [9:0]  pc;
      logic [31:0] inst;
   } ent_t;

   logic        clk = 1'b0;
   logic        clear = 1'b0;
   logic        flush = 1'b0;
   logic        ready_id = 1'b1;
   logic        vi1 = 1'b0, vi0 = 1'b0;
   logic [9:0]  pi1 = 10'h0, pi0 = 10'h0;
   logic [31:0] ii1 = 32'h0, ii0 = 32'h0;
   logic        rdy1, rdy0, v1, v0;
   logic [9:0]  pc1, pc0;
   logic [31:0] inst1, inst0;

   int checks = 0;
   int errors = 0;
   ent_t q1[$];
   ent_t q0[$];

   always #5 clk = ~clk;

   if_id_stage_buf #(.SKID_EN(1)) dut_skid (
      .clk(clk), .clear(clear), .valid_if(vi1), .pc_if(pi1), .inst_if(ii1),
      .ready_if(rdy1), .flush(flush), .valid_id(v1), .pc_id(pc1),
      .inst_id(inst1), .ready_id(ready_id)
   );

   if_id_stage_buf #(.SKID_EN(0)) dut_noskid (
      .clk(clk), .clear(clear), .valid_if(vi0), .pc_if(pi0), .inst_if(ii0),
      .ready_if(rdy0), .flush(flush), .valid_id(v0), .pc_id(pc0),
      .inst_id(inst0), .ready_id(ready_id)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mk_inst(input logic [9:0] p);
      return {12'hC0D, 10'h155, p};
   endfunction

   task automatic drive(input logic a_v, input logic [9:0] a_p,
                        input logic b_v, input logic [9:0] b_p,
                        input logic rid, input logic fl);
      vi1 = a_v; pi1 = a_p; ii1 = mk_inst(a_p);
      vi0 = b_v; pi0 = b_p; ii0 = mk_inst(b_p);
      ready_id = rid;
      flush = fl;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: compare outputs with FIFO heads, then model the edge
   always @(negedge clk) begin
      logic exp_r1, exp_r0;
      ent_t e;
      if (clear) begin
         q1.delete();
         q0.delete();
      end else begin
         exp_r1 = (q1.size() != 2);
         chk("sb_ready_skid", 32'(rdy1), 32'(exp_r1));
         chk("sb_valid_skid", 32'(v1), 32'(q1.size() != 0));
         if (q1.size() != 0) begin
            chk("sb_pc_skid", 32'(pc1), 32'(q1[0].pc));
            chk("sb_inst_skid", inst1, q1[0].inst);
            if (ready_id) void'(q1.pop_front());
         end else begin
            chk("sb_bubble_skid", inst1, NOP);
         end
         if (flush) q1.delete();
         else if (vi1 && exp_r1) begin
            e.pc = pi1; e.inst = ii1; q1.push_back(e);
         end

         exp_r0 = ready_id || (q0.size() == 0);
         chk("sb_ready_noskid", 32'(rdy0), 32'(exp_r0));
         chk("sb_valid_noskid", 32'(v0), 32'(q0.size() != 0));
         if (q0.size() != 0) begin
            chk("sb_pc_noskid", 32'(pc0), 32'(q0[0].pc));
            chk("sb_inst_noskid", inst0, q0[0].inst);
            if (ready_id) void'(q0.pop_front());
         end else begin
            chk("sb_bubble_noskid", inst0, NOP);
         end
         if (flush) q0.delete();
         else if (vi0 && exp_r0) begin
            e.pc = pi0; e.inst = ii0; q0.push_back(e);
         end
      end
   end

   initial begin
      logic [9:0] p;
      // Asynchronous reset values
      #1 clear = 1'b1;
      #2;
      chk("rst_valid", 32'(v1), 32'd0);
      chk("rst_pc", 32'(pc1), 32'd0);
      chk("rst_inst", inst1, NOP);
      chk("rst_ready_skid", 32'(rdy1), 32'd1);
      chk("rst_ready_noskid", 32'(rdy0), 32'd1);
      tick;
      clear = 1'b0;

      // Streaming at full rate
      for (int i = 0; i < 4; i++) begin
         p = 10'(4 + 4 * i);
         drive(1'b1, p, 1'b1, p, 1'b1, 1'b0);
         tick;
         chk("stream_pc_skid", 32'(pc1), 32'(p));
         chk("stream_pc_noskid", 32'(pc0), 32'(p));
         chk("stream_valid", 32'(v1), 32'd1);
         chk("stream_ready", 32'(rdy1), 32'd1);
      end
      drive(1'b0, 10'h0, 1'b0, 10'h0, 1'b1, 1'b0);
      tick;

      // Stall: 0x020 accepted, 0x024 offered with ready_id low for 3 cycles
      drive(1'b1, 10'h020, 1'b1, 10'h020, 1'b1, 1'b0);
      tick;
      drive(1'b1, 10'h024, 1'b1, 10'h024, 1'b0, 1'b0);
      #1 chk("stall_ready_noskid_low", 32'(rdy0), 32'd0);
      tick;
      chk("stall_ready_skid_low", 32'(rdy1), 32'd0);
      chk("stall_hold_skid", 32'(pc1), 32'h020);
      chk("stall_hold_noskid", 32'(pc0), 32'h020);
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 10'h0, 1'b1, 10'h024, 1'b0, 1'b0);
         tick;
         chk("stall2_ready_skid", 32'(rdy1), 32'd0);
         chk("stall2_pc_skid", 32'(pc1), 32'h020);
      end
      drive(1'b0, 10'h0, 1'b1, 10'h024, 1'b1, 1'b0);
      #1 chk("release_ready_noskid", 32'(rdy0), 32'd1);
      tick;
      chk("release_pc_skid", 32'(pc1), 32'h024);
      chk("release_pc_noskid", 32'(pc0), 32'h024);
      chk("release_ready_skid", 32'(rdy1), 32'd1);
      drive(1'b0, 10'h0, 1'b0, 10'h0, 1'b1, 1'b0);
      tick;

      // Flush while SKID with 0x030 presented
      drive(1'b1, 10'h040, 1'b1, 10'h040, 1'b1, 1'b0);
      tick;
      drive(1'b1, 10'h044, 1'b1, 10'h044, 1'b0, 1'b0);
      tick;
      chk("pre_flush_skid_full", 32'(rdy1), 32'd0);
      drive(1'b1, 10'h030, 1'b1, 10'h030, 1'b0, 1'b1);
      tick;
      chk("flush_valid_skid", 32'(v1), 32'd0);
      chk("flush_inst_skid", inst1, NOP);
      chk("flush_valid_noskid", 32'(v0), 32'd0);
      chk("flush_ready_skid", 32'(rdy1), 32'd1);
      drive(1'b0, 10'h0, 1'b0, 10'h0, 1'b1, 1'b0);
      tick;
      chk("flush_drop_skid", 32'(v1), 32'd0);
      chk("flush_drop_noskid", 32'(v0), 32'd0);

      // Asynchronous clear mid-stream
      drive(1'b1, 10'h050, 1'b1, 10'h050, 1'b1, 1'b0);
      tick;
      drive(1'b1, 10'h054, 1'b1, 10'h054, 1'b1, 1'b0);
      tick;
      drive(1'b0, 10'h0, 1'b0, 10'h0, 1'b1, 1'b0);
      #2 clear = 1'b1;
      #1;
      chk("clr_valid_skid", 32'(v1), 32'd0);
      chk("clr_pc_skid", 32'(pc1), 32'd0);
      chk("clr_valid_noskid", 32'(v0), 32'd0);
      chk("clr_pc_noskid", 32'(pc0), 32'd0);
      tick;
      clear = 1'b0;
      drive(1'b1, 10'h100, 1'b1, 10'h100, 1'b1, 1'b0);
      tick;
      chk("post_clr_pc_skid", 32'(pc1), 32'h100);
      chk("post_clr_valid_skid", 32'(v1), 32'd1);
      chk("post_clr_pc_noskid", 32'(pc0), 32'h100);

      // Random traffic against the FIFO scoreboard
      for (int i = 0; i < 10000; i++) begin
         drive($urandom_range(0, 3) != 0, 10'($urandom), $urandom_range(0, 3) != 0,
               10'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
         tick;
      end
      drive(1'b0, 10'h0, 1'b0, 10'h0, 1'b1, 1'b0);
      repeat (4) tick;
      @(negedge clk);
      #1;
      chk("drain_skid", 32'(q1.size()), 32'd0);
      chk("drain_noskid", 32'(q0.size()), 32'd0);
      chk("drain_valid_skid", 32'(v1), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_if_id_stage_buf

// File: doc/if_id_stage_buf.md
# if_id_stage_buf

Parametrised successor to the plain IF/ID pipeline register: a one-deep pipeline stage carrying `{pc, inst}` with a valid/ready handshake on both sides, an optional second skid entry that keeps `ready_if` free of any combinational path from `ready_id`, and a synchronous flush that inserts a NOP bubble. It sits between instruction fetch and decode, and can be reused for any stage boundary that carries an address/word pair.

## Interface
Parameters:
- `DATA_SIZE`, 32: instruction/data word width.
- `ADDR_SIZE`, 10: PC width.
- `SKID_EN`, 1: 1 enables the two-entry skid buffer. 0 gives a single entry with a pass-through ready.
- `BUBBLE_INST`, 32'h0000_0013: word presented on `inst_id` whenever `valid_id`=0 (`addi x0,x0,0`).

Ports:
- `clk`, in, 1: clock, rising edge.
- `clear`, in, 1: asynchronous, active-high reset.
- `valid_if`, in, 1: fetch presents a word.
- `pc_if`, in, ADDR_SIZE: fetch PC.
- `inst_if`, in, DATA_SIZE: fetch word.
- `ready_if`, out, 1: stage can accept.
- `flush`, in, 1: synchronous kill of all held and incoming entries.
- `valid_id`, out, 1: decode output valid.
- `pc_id`, out, ADDR_SIZE: held PC.
- `inst_id`, out, DATA_SIZE: held word, or `BUBBLE_INST` when not valid.
- `ready_id`, in, 1: decode accepts (low = stall).

## Operation
- Accept = `valid_if & ready_if`. Retire = `valid_id & ready_id`.
- Storage:
  - Main slot M drives `pc_id` and `inst_id`.
  - Skid slot S exists only when `SKID_EN`=1.
- States: EMPTY, FULL, SKID (M and S both hold entries).
- `SKID_EN`=1:
  - `ready_if` = (state != SKID). It is a function of registered state only.
  - EMPTY: accept → load M, go to FULL.
  - FULL, retire & accept → load M, stay FULL.
  - FULL, retire & no accept → EMPTY.
  - FULL, no retire & accept → load S, go to SKID.
  - FULL, no retire & no accept → hold.
  - SKID, retire → M ← S, go to FULL. Otherwise hold.
  - No accept is possible in SKID.
- `SKID_EN`=0:
  - `ready_if` = `ready_id | ~valid_id`.
  - The SKID state is never entered.
  - FULL with retire & accept reloads M.
- Flush:
  - `flush`=1 forces EMPTY at the next edge and overrides every other transition.
  - An input presented in the flush cycle is discarded even if `ready_if`=1.
  - An output retired in the flush cycle is still retired (decode sees it). Squashing it is the hazard unit's responsibility.
- Outputs:
  - `valid_id` = (state != EMPTY).
  - `inst_id` = `valid_id` ? M.inst : `BUBBLE_INST`.
  - `pc_id` = M.pc in every state; it is not masked.
- Ordering: entries retire strictly in accept order. No entry is duplicated or lost except by flush.

## Timing
- Reset (`clear` high, asynchronous):
  - State EMPTY.
  - M and S cleared to 0.
  - `valid_id`=0, `pc_id`=0, `inst_id`=`BUBBLE_INST`, `ready_if`=1.
- Release of `clear` is synchronous to `clk`. The first accept can occur on the first edge after release.
- Latency is 1 cycle, accept edge to `valid_id`.
- Throughput is 1 entry/cycle with `ready_id` held high, for both `SKID_EN` values.
- After a stall:
  - Deassert of `ready_id` stops accepts from the cycle after S fills.
  - When `ready_id` reasserts, `ready_if` returns high one cycle later, with no bubble on the output.
- Flush takes effect at the next edge: `valid_id`=0 in the following cycle and `ready_if`=1.
- Asserting `clear` mid-transfer discards M and S immediately (asynchronously).

## Structure
- Shared package `pipe_pkg`:
  - `typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} pipe_state_t;`
  - constant `RV_NOP = 32'h0000_0013`.
- Sub-module `pipe_slot`:
  - Enable-loaded `{pc, inst}` register with asynchronous `clear`.
  - Instantiated once for M, plus once for S under a `SKID_EN` generate.
- Top-level module contains only the state register, next-state logic and output muxing.

## Test plan
- Reset, then stream pc 0x004..0x010 with `ready_id`=1 → `pc_id` follows one cycle later, `valid_id` stays high, `ready_if` stays 1.
- `SKID_EN`=1: accept pc 0x020 and 0x024, drop `ready_id` for 3 cycles → `ready_if`=0 from the cycle after 0x024 is accepted, `pc_id` holds 0x020. On release, 0x020 then 0x024 retire in order.
- `SKID_EN`=0, same stimulus → `ready_if` tracks `ready_id` combinationally, and 0x024 stays upstream until the stall clears.
- `flush` pulse while in SKID with `valid_if`=1 (pc 0x030) → next cycle `valid_id`=0, `inst_id`=0x00000013, and 0x030 never appears at the output.
- Assert `clear` mid-stream (async, between edges) → `valid_id`=0 and `pc_id`=0 immediately. After release, the first accepted pc 0x100 appears one cycle later.
- Random `valid_if`/`ready_id`/`flush` for 10k cycles against a FIFO scoreboard → no loss, duplication or reorder except entries killed by flush.
